// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple-borrow subtractor, computes a - b - bin
// one bit per clock, LSB first, behind a start/busy/done handshake.
// Optional feature: define SERIAL_SUB_SIGNED_OVF_EN to compute the signed
// overflow flag; when undefined, ovf is tied low and no extra flops exist.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               br_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               busy_q;
    logic               done_q;

    logic               dbit_d;
    logic               br_d;
    logic [WIDTH-1:0]   res_d;
    logic               last_shift;

    // Full-subtractor cell on the current LSBs plus the running borrow
    always_comb begin
        dbit_d     = a_q[0] ^ b_q[0] ^ br_q;
        br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d      = {dbit_d, res_q[WIDTH-1:1]};
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM with registered handshake outputs and the serial datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result is only published here, so diff/bout stay stable while shifting
                    diff_q  <= res_q;
                    bout_q  <= br_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Operand sign bits are shifted out of a_q/b_q, so keep copies for the overflow test
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == S_DONE) begin
            ovf_q <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations captured by do_op
    int               obs_busy;
    int               obs_done;
    int               obs_lat;
    logic             obs_changed;
    logic [WIDTH-1:0] obs_diff;
    logic             obs_bout;
    logic             obs_ovf;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .diff    (diff),
        .bout    (bout),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic
    function automatic logic [WIDTH-1:0] m_diff(input int ta, input int tb, input int tbin);
        int r;
        r = ta - tb - tbin;
        return r[WIDTH-1:0];
    endfunction

    function automatic logic m_bout(input int ta, input int tb, input int tbin);
        return (ta < tb + tbin);
    endfunction

    function automatic logic m_ovf(input int ta, input int tb, input int tbin);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        logic [WIDTH-1:0] av, bv, dv;
        av = ta[WIDTH-1:0];
        bv = tb[WIDTH-1:0];
        dv = m_diff(ta, tb, tbin);
        return (av[WIDTH-1] != bv[WIDTH-1]) && (dv[WIDTH-1] != av[WIDTH-1]);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one operation from IDLE and record handshake/result behaviour
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
        logic [WIDTH-1:0] held;
        @(posedge clk); #1;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        obs_busy = 0; obs_done = 0; obs_lat = -1; obs_changed = 1'b0;
        held = diff; obs_diff = 'x; obs_bout = 1'bx; obs_ovf = 1'bx;
        for (int i = 0; i < WIDTH + 6; i++) begin
            if (busy === 1'b1) obs_busy++;
            if (done === 1'b1) begin
                obs_done++;
                if (obs_lat < 0) begin
                    obs_lat  = i;
                    obs_diff = diff;
                    obs_bout = bout;
                    obs_ovf  = ovf;
                end
            end else if (obs_done == 0 && diff !== held) begin
                obs_changed = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff got=%0d exp=0", diff); end
        n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got=%b exp=0", bout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_start got busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_directed;
        int va[4] = '{9, 5, 0, 15};
        int vb[4] = '{5, 9, 0, 15};
        int vi[4] = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            do_op(WIDTH'(va[k]), WIDTH'(vb[k]), 1'(vi[k]));
            n_tests++; if (obs_diff !== m_diff(va[k], vb[k], vi[k])) begin
                n_fail++; $display("FAIL dir_diff[%0d] got=%0d exp=%0d", k, obs_diff, m_diff(va[k], vb[k], vi[k]));
            end
            n_tests++; if (obs_bout !== m_bout(va[k], vb[k], vi[k])) begin
                n_fail++; $display("FAIL dir_bout[%0d] got=%b exp=%b", k, obs_bout, m_bout(va[k], vb[k], vi[k]));
            end
            n_tests++; if (obs_busy != WIDTH + 1) begin
                n_fail++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", k, obs_busy, WIDTH + 1);
            end
            n_tests++; if (obs_done != 1) begin
                n_fail++; $display("FAIL dir_done_pulses[%0d] got=%0d exp=1", k, obs_done);
            end
            n_tests++; if (obs_lat != WIDTH + 1) begin
                n_fail++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", k, obs_lat, WIDTH + 1);
            end
            n_tests++; if (obs_changed !== 1'b0) begin
                n_fail++; $display("FAIL dir_diff_stable[%0d] got=changed exp=held", k);
            end
        end
    endtask

    task automatic test_random;
        int ra, rb, ri;
        for (int k = 0; k < 30; k++) begin
            ra = int'($urandom_range(MAXV, 0));
            rb = int'($urandom_range(MAXV, 0));
            ri = int'($urandom_range(1, 0));
            do_op(WIDTH'(ra), WIDTH'(rb), 1'(ri));
            n_tests++; if (obs_diff !== m_diff(ra, rb, ri) || obs_bout !== m_bout(ra, rb, ri)
                           || obs_ovf !== m_ovf(ra, rb, ri) || obs_done != 1) begin
                n_fail++;
                $display("FAIL rand a=%0d b=%0d bin=%0d got diff=%0d bout=%b ovf=%b done=%0d exp diff=%0d bout=%b ovf=%b done=1",
                         ra, rb, ri, obs_diff, obs_bout, obs_ovf, obs_done,
                         m_diff(ra, rb, ri), m_bout(ra, rb, ri), m_ovf(ra, rb, ri));
            end
        end
    endtask

    task automatic test_start_ignored;
        int dcnt;
        logic [WIDTH-1:0] dval;
        @(posedge clk); #1;
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0; dval = 'x;
        for (int i = 0; i < WIDTH + 8; i++) begin
            if (done === 1'b1) begin dcnt++; dval = diff; end
            @(posedge clk); #1;
        end
        n_tests++; if (dcnt != 1) begin n_fail++; $display("FAIL ignore_done_pulses got=%0d exp=1", dcnt); end
        n_tests++; if (dval !== 4'd5) begin n_fail++; $display("FAIL ignore_diff got=%0d exp=5", dval); end
    endtask

    task automatic test_reset_midop;
        int dcnt;
        @(posedge clk); #1;
        a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++; if (diff !== '0 || bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset got diff=%0d bout=%b busy=%b done=%b ovf=%b exp all 0", diff, bout, busy, done, ovf);
        end
        @(negedge clk); reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        n_tests++; if (dcnt != 0) begin n_fail++; $display("FAIL midop_no_done got=%0d active cycles exp=0", dcnt); end
        do_op(4'd3, 4'd1, 1'b0);
        n_tests++; if (obs_diff !== 4'd2 || obs_bout !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_op got diff=%0d bout=%b exp diff=2 bout=0", obs_diff, obs_bout);
        end
    endtask

    task automatic test_back_to_back;
        int first_i, second_i, dcnt;
        logic [WIDTH-1:0] d1, d2;
        @(posedge clk); #1;
        a = 4'd10; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd2; b = 4'd6; bin = 1'b1;
        first_i = -1; second_i = -1; dcnt = 0; d1 = 'x; d2 = 'x;
        for (int i = 0; i < 2 * (WIDTH + 2) + 2; i++) begin
            if (done === 1'b1) begin
                dcnt++;
                if (first_i < 0) begin first_i = i; d1 = diff; end
                else if (second_i < 0) begin second_i = i; d2 = diff; end
            end
            if (i == 2 * (WIDTH + 2) - 1) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (WIDTH + 3) @(posedge clk);
        #1;
        n_tests++; if (d1 !== 4'd6) begin n_fail++; $display("FAIL b2b_first_diff got=%0d exp=6", d1); end
        n_tests++; if (d2 !== m_diff(2, 6, 1)) begin n_fail++; $display("FAIL b2b_second_diff got=%0d exp=%0d", d2, m_diff(2, 6, 1)); end
        n_tests++; if (second_i - first_i != WIDTH + 2) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", second_i - first_i, WIDTH + 2);
        end
    endtask

    task automatic test_ovf;
        do_op(4'd8, 4'd1, 1'b0);
        n_tests++; if (obs_diff !== 4'd7 || obs_bout !== 1'b0 || obs_ovf !== m_ovf(8, 1, 0)) begin
            n_fail++; $display("FAIL ovf_neg8_minus1 got diff=%0d bout=%b ovf=%b exp diff=7 bout=0 ovf=%b",
                               obs_diff, obs_bout, obs_ovf, m_ovf(8, 1, 0));
        end
        do_op(4'd3, 4'd1, 1'b0);
        n_tests++; if (obs_diff !== 4'd2 || obs_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_3_minus1 got diff=%0d ovf=%b exp diff=2 ovf=0", obs_diff, obs_ovf);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_reset_midop;
        test_back_to_back;
        test_ovf;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial ripple-borrow subtractor. It computes A - B - Bin over WIDTH clocks, one bit per cycle, LSB first. It is the inverse-direction companion to the board's combinational adder and sits between the switch inputs and the LEDR/HEX display logic on the DE1_SoC top level. It uses a start/busy/done handshake so the top level can trigger one subtraction per KEY press.

Parameters:
WIDTH, 4, operand width in bits (minimum 2).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request a subtraction; sampled only in IDLE.
a  input  WIDTH  minuend, unsigned (or two's complement with the optional feature).
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
bout  output  1  final borrow out; 1 when a < b + bin (unsigned).
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse when diff/bout become valid.
ovf  output  1  signed overflow flag (optional feature; 0 when compiled out).

Behaviour:
- Reset (async, reset_n=0): FSM goes to IDLE; diff=0, bout=0, busy=0, done=0, ovf=0; internal shift registers, borrow and counter are cleared. A reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. When start=1, load a, b and bin into internal registers, clear the bit counter, and go to SHIFT. When start=0, stay in IDLE and hold diff/bout/ovf.
- SHIFT: busy=1. Each cycle:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - shift d into the result register at the MSB, shifting right
  - shift the a and b registers right
  - increment the counter
  - after exactly WIDTH SHIFT cycles, go to DONE.
- DONE: busy=1. Transfer the result register to diff, the final borrow to bout, and the overflow (if enabled) to ovf. done=1 for this cycle only. Return to IDLE.
- Latency: start sampled at edge N -> done high in the cycle following edge N+WIDTH+1; diff/bout update on that same edge.
- diff, bout and ovf are registered and hold their value until the next DONE. They do not change during SHIFT.
- start while busy=1 is ignored, not queued. start held high continuously yields back-to-back operations with one IDLE cycle between them.
- a, b and bin may change freely after the start edge; only the values latched in IDLE are used.
- Wrap-around: results are modulo 2^WIDTH, e.g. 0 - 1 = all ones with bout=1.

Optional Feature:
Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined: ovf is computed in DONE as (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operand MSBs. It is registered alongside diff.
- Undefined: ovf is tied to 0 and no extra flops are inferred.

Test Plan:
- Reset then a=9, b=5, bin=0, pulse start -> busy high 5 cycles, done one cycle, diff=4, bout=0.
- a=5, b=9, bin=0 -> diff=12 (4'b1100), bout=1.
- a=0, b=0, bin=1 -> diff=15, bout=1. Then a=15, b=15, bin=0 -> diff=0, bout=0.
- Start a=7, b=2. Re-assert start with a=1, b=1 during SHIFT -> second start ignored; diff=5, exactly one done pulse.
- Start a=12, b=3. Assert reset_n=0 after 2 SHIFT cycles -> all outputs 0 immediately, no done pulse. A new op afterwards with a=3, b=1 gives diff=2.
- With SERIAL_SUB_SIGNED_OVF_EN: a=8 (-8), b=1 -> diff=7, ovf=1, bout=0. Then a=3, b=1 -> ovf=0. Without the macro, ovf=0 for both.
